// File: rtl/msrv32_rf_wr_arbiter.sv
// Register-file writeback arbiter for the msrv32 core.
// Three writeback sources (ALU, load unit, CSR unit) compete for the single
// register-file write port. A round-robin pointer picks the winner each
// cycle. The winning write is registered and appears one cycle later.
// Writes to x0 are accepted from the requester but never reach the register file.
module msrv32_rf_wr_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            ms_risc32_mp_clk_in,
  input  logic            ms_risc32_mp_rst_in,
  input  logic            hold_in,
  input  logic            req_0_valid_in,
  input  logic [4:0]      req_0_rd_addr_in,
  input  logic [XLEN-1:0] req_0_data_in,
  input  logic            req_1_valid_in,
  input  logic [4:0]      req_1_rd_addr_in,
  input  logic [XLEN-1:0] req_1_data_in,
  input  logic            req_2_valid_in,
  input  logic [4:0]      req_2_rd_addr_in,
  input  logic [XLEN-1:0] req_2_data_in,
  output logic            req_0_ready_out,
  output logic            req_1_ready_out,
  output logic            req_2_ready_out,
  output logic            wr_en_out,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_out,
  output logic [1:0]      grant_id_out
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_CSR  = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  logic [1:0]      rr_ptr;
  logic [1:0]      rr_ptr_next;
  logic            gnt_vld;
  src_e            gnt_src;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  // Pick the first valid requester starting from rr_ptr; stall and reset suppress any grant.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    gnt_vld = 1'b0;
    gnt_src = SRC_NONE;
    case (rr_ptr)
      2'd1: begin
        if (req_1_valid_in)      begin gnt_vld = 1'b1; gnt_src = SRC_LSU; end
        else if (req_2_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_CSR; end
        else if (req_0_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_ALU; end
      end
      2'd2: begin
        if (req_2_valid_in)      begin gnt_vld = 1'b1; gnt_src = SRC_CSR; end
        else if (req_0_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_ALU; end
        else if (req_1_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_LSU; end
      end
      default: begin
        if (req_0_valid_in)      begin gnt_vld = 1'b1; gnt_src = SRC_ALU; end
        else if (req_1_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_LSU; end
        else if (req_2_valid_in) begin gnt_vld = 1'b1; gnt_src = SRC_CSR; end
      end
    endcase
    if (hold_in || ms_risc32_mp_rst_in) begin
      gnt_vld = 1'b0;
      gnt_src = SRC_NONE;
    end
  end

  assign req_0_ready_out = gnt_vld && (gnt_src == SRC_ALU);
  assign req_1_ready_out = gnt_vld && (gnt_src == SRC_LSU);
  assign req_2_ready_out = gnt_vld && (gnt_src == SRC_CSR);

  // Route the winner's destination and data, and compute the pointer after this grant.
  always_comb begin
    sel_addr    = 5'd0;
    sel_data    = '0;
    rr_ptr_next = rr_ptr;
    case (gnt_src)
      SRC_ALU: begin sel_addr = req_0_rd_addr_in; sel_data = req_0_data_in; rr_ptr_next = 2'd1; end
      SRC_LSU: begin sel_addr = req_1_rd_addr_in; sel_data = req_1_data_in; rr_ptr_next = 2'd2; end
      SRC_CSR: begin sel_addr = req_2_rd_addr_in; sel_data = req_2_data_in; rr_ptr_next = 2'd0; end
      default: ;
    endcase
  end

  // Advance the pointer on a grant and register the write; x0 targets and idle cycles produce no write.
  always_ff @(posedge ms_risc32_mp_clk_in) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (ms_risc32_mp_rst_in) begin
      rr_ptr       <= 2'd0;
      wr_en_out    <= 1'b0;
      rd_addr_out  <= 5'd0;
      rd_out       <= '0;
      grant_id_out <= SRC_NONE;
    end else begin
      rr_ptr <= rr_ptr_next;
      if (gnt_vld && (sel_addr != 5'd0)) begin
        wr_en_out    <= 1'b1;
        rd_addr_out  <= sel_addr;
        rd_out       <= sel_data;
        grant_id_out <= gnt_src;
      end else begin
        wr_en_out    <= 1'b0;
        grant_id_out <= SRC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_rf_wr_arbiter.sv
// Directed testbench for msrv32_rf_wr_arbiter with hand-computed expectations.
module tb_msrv32_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        v0, v1, v2;
  logic [4:0]  a0, a1, a2;
  logic [31:0] d0, d1, d2;
  logic        r0, r1, r2;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  gid;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  msrv32_rf_wr_arbiter #(.XLEN(32)) dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst),
    .hold_in             (hold),
    .req_0_valid_in      (v0),
    .req_0_rd_addr_in    (a0),
    .req_0_data_in       (d0),
    .req_1_valid_in      (v1),
    .req_1_rd_addr_in    (a1),
    .req_1_data_in       (d1),
    .req_2_valid_in      (v2),
    .req_2_rd_addr_in    (a2),
    .req_2_data_in       (d2),
    .req_0_ready_out     (r0),
    .req_1_ready_out     (r1),
    .req_2_ready_out     (r2),
    .wr_en_out           (wr_en),
    .rd_addr_out         (rd_addr),
    .rd_out              (rd_data),
    .grant_id_out        (gid)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle where combinational ready is sampled.
  task automatic mid();
    #4;
  endtask

  task automatic check_write(input string tag, input logic en, input logic [4:0] a,
                             input logic [31:0] d, input logic [1:0] g);
    check({tag, ".wr_en"},   wr_en,   en);
    check({tag, ".rd_addr"}, rd_addr, a);
    check({tag, ".rd_out"},  rd_data, d);
    check({tag, ".gid"},     gid,     g);
  endtask

  task automatic do_reset();
    rst = 1'b1; hold = 1'b0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    a0 = 5'd0; a1 = 5'd0; a2 = 5'd0;
    d0 = '0;   d1 = '0;   d2 = '0;

    // Reset: ready forced low even with a valid request, outputs at reset values.
    tick();
    v0 = 1'b1; a0 = 5'd4; d0 = 32'h0000_0444;
    mid();
    check("rst.ready", {r2, r1, r0}, 3'b000);
    tick();
    check_write("rst", 1'b0, 5'd0, 32'h0, 2'd3);
    v0 = 1'b0;

    // Single request from the load unit.
    do_reset();
    v1 = 1'b1; a1 = 5'd5; d1 = 32'hDEAD_BEEF;
    mid();
    check("single.ready", {r2, r1, r0}, 3'b010);
    tick();
    v1 = 1'b0;
    check_write("single", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1);
    // rr_ptr = 2 now

    // x0 write from CSR unit: accepted, but no register-file write.
    v2 = 1'b1; a2 = 5'd0; d2 = 32'h1234_5678;
    mid();
    check("x0.ready", {r2, r1, r0}, 3'b100);
    tick();
    v2 = 1'b0;
    check_write("x0", 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd3);

    // Probe rr_ptr == 0: all three valid must grant source 0 (targets x0, no write).
    v0 = 1'b1; v1 = 1'b1; v2 = 1'b1; a0 = 5'd0; a1 = 5'd0; a2 = 5'd0;
    mid();
    check("probe.ready", {r2, r1, r0}, 3'b001);
    tick();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    check_write("probe", 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd3);
    // rr_ptr = 1 now

    // Hold for 4 cycles with req_0/req_1 valid, then resume from rr_ptr = 1.
    hold = 1'b1;
    v0 = 1'b1; a0 = 5'd10; d0 = 32'h0000_0100;
    v1 = 1'b1; a1 = 5'd11; d1 = 32'h0000_0111;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("hold%0d.ready", i), {r2, r1, r0}, 3'b000);
      tick();
      check($sformatf("hold%0d.wr_en", i), wr_en, 1'b0);
      check($sformatf("hold%0d.gid", i), gid, 2'd3);
    end
    hold = 1'b0;
    mid();
    check("resume1.ready", {r2, r1, r0}, 3'b010);
    tick();
    v1 = 1'b0;
    check_write("resume1", 1'b1, 5'd11, 32'h0000_0111, 2'd1);
    mid();
    check("resume2.ready", {r2, r1, r0}, 3'b001);
    tick();
    v0 = 1'b0;
    hold = 1'b1;  // a registered write is not squashed by a later stall
    check_write("resume2", 1'b1, 5'd10, 32'h0000_0100, 2'd0);
    hold = 1'b0;
    tick();
    check_write("idle", 1'b0, 5'd10, 32'h0000_0100, 2'd3);

    // All three continuously valid from reset: grants 0,1,2,0,1,2.
    do_reset();
    v0 = 1'b1; a0 = 5'd1; d0 = 32'hA0A0_0001;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'hA1A1_0002;
    v2 = 1'b1; a2 = 5'd3; d2 = 32'hA2A2_0003;
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  exp_rdy;
      logic [4:0]  exp_a;
      logic [31:0] exp_d;
      logic [1:0]  exp_g;
      case (i % 3)
        0: begin exp_rdy = 3'b001; exp_a = 5'd1; exp_d = 32'hA0A0_0001; exp_g = 2'd0; end
        1: begin exp_rdy = 3'b010; exp_a = 5'd2; exp_d = 32'hA1A1_0002; exp_g = 2'd1; end
        default: begin exp_rdy = 3'b100; exp_a = 5'd3; exp_d = 32'hA2A2_0003; exp_g = 2'd2; end
      endcase
      mid();
      check($sformatf("rr%0d.ready", i), {r2, r1, r0}, exp_rdy);
      tick();
      check_write($sformatf("rr%0d", i), 1'b1, exp_a, exp_d, exp_g);
    end
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

    // Same destination from two sources: x7 gets A then B.
    do_reset();
    v0 = 1'b1; a0 = 5'd7; d0 = 32'hAAAA_5555;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'hBBBB_6666;
    mid();
    check("same_rd1.ready", {r2, r1, r0}, 3'b001);
    tick();
    v0 = 1'b0;
    check_write("same_rd1", 1'b1, 5'd7, 32'hAAAA_5555, 2'd0);
    mid();
    check("same_rd2.ready", {r2, r1, r0}, 3'b010);
    tick();
    v1 = 1'b0;
    check_write("same_rd2", 1'b1, 5'd7, 32'hBBBB_6666, 2'd1);
    // rr_ptr = 2 now

    // Reset in the same cycle as a req_0 transfer attempt.
    rst = 1'b1;
    v0 = 1'b1; a0 = 5'd9; d0 = 32'h9999_0009;
    mid();
    check("rst_mid.ready", {r2, r1, r0}, 3'b000);
    tick();
    rst = 1'b0;
    check_write("rst_mid", 1'b0, 5'd0, 32'h0, 2'd3);
    // First post-reset grant follows rr_ptr = 0: source 0 wins over source 2.
    v2 = 1'b1; a2 = 5'd12; d2 = 32'h2222_000C;
    mid();
    check("post_rst.ready", {r2, r1, r0}, 3'b001);
    tick();
    v0 = 1'b0;
    check_write("post_rst", 1'b1, 5'd9, 32'h9999_0009, 2'd0);
    mid();
    check("post_rst2.ready", {r2, r1, r0}, 3'b100);
    tick();
    v2 = 1'b0;
    check_write("post_rst2", 1'b1, 5'd12, 32'h2222_000C, 2'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_rf_wr_arbiter.md
MSRV32_RF_WR_ARBITER -- requirements
Module: msrv32_rf_wr_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of every writeback data path; only 32 is supported.
REQ-002 ms_risc32_mp_clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 ms_risc32_mp_rst_in  input  1  reset, synchronous, active-high.
REQ-004 hold_in  input  1  pipeline stall; when 1, no grant is issued.
REQ-005 req_0_valid_in / req_1_valid_in / req_2_valid_in  input  1 each  writeback request from ALU (0), load unit (1), CSR unit (2).
REQ-006 req_0_rd_addr_in / req_1_rd_addr_in / req_2_rd_addr_in  input  5 each  destination register index.
REQ-007 req_0_data_in / req_1_data_in / req_2_data_in  input  XLEN each  writeback value.
REQ-008 req_0_ready_out / req_1_ready_out / req_2_ready_out  output  1 each  grant; a transfer occurs when valid and ready are both 1.
REQ-009 wr_en_out  output  1  register-file write enable.
REQ-010 rd_addr_out  output  5  register-file write index.
REQ-011 rd_out  output  XLEN  register-file write data.
REQ-012 grant_id_out  output  2  source of the write on the current wr_en_out cycle (0/1/2); 3 when no write.

Function
REQ-013 State: 2-bit round-robin pointer rr_ptr, values 0..2 only; value 3 is unreachable.
REQ-014 Arbitration: when hold_in=0, grant the first valid requester in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
REQ-015 At most one ready_out is 1 in any cycle; ready_out is combinational from the valid inputs, hold_in and rr_ptr.
REQ-016 When hold_in=1 or no requester is valid, all ready_out are 0 and rr_ptr holds.
REQ-017 On a grant to source k, rr_ptr becomes (k+1) mod 3 at the next edge.
REQ-018 Requester rule: once valid is raised, valid, rd_addr and data stay stable until the transfer cycle; the arbiter does not check this rule.
REQ-019 Write latency is 1 cycle: a transfer in cycle N drives wr_en_out, rd_addr_out, rd_out and grant_id_out (all registered) in cycle N+1.
REQ-020 A transfer with rd_addr=0 is accepted (ready=1 and rr_ptr advances), but wr_en_out=0 in cycle N+1; rd_addr_out and rd_out hold their previous values and grant_id_out=3.
REQ-021 In cycles with no transfer, wr_en_out=0 and grant_id_out=3 in the next cycle; rd_addr_out and rd_out hold their previous values.
REQ-022 Fairness: with hold_in=0, any continuously valid requester is granted within 3 cycles.
REQ-023 When several requesters target the same rd in one cycle, they are written in grant order; the last write wins.
REQ-024 hold_in does not squash a write already registered; the cycle-N+1 write still occurs.

Reset
REQ-025 When ms_risc32_mp_rst_in=1 at an edge: rr_ptr=0, wr_en_out=0, rd_addr_out=0, rd_out=0, grant_id_out=3.
REQ-026 During reset, all ready_out are forced to 0 regardless of valid.
REQ-027 Reset asserted mid-stream discards any transfer in that cycle; the first post-reset grant follows rr_ptr=0.

Verification
REQ-028 Reset then single request: req_1 valid, rd=5, data=0xDEADBEEF -> req_1_ready=1 same cycle; next cycle wr_en=1, rd_addr=5, rd_out=0xDEADBEEF, grant_id=1.
REQ-029 All three valid continuously from reset, rd=1/2/3 -> grants 0,1,2,0,... on consecutive cycles; writes to x1,x2,x3 appear one cycle later, each with the matching grant_id.
REQ-030 req_2 valid with rd=0, data=0x12345678 -> req_2_ready=1; next cycle wr_en=0, grant_id=3, rd_out unchanged; rr_ptr=0 afterwards.
REQ-031 hold_in=1 for 4 cycles with req_0 and req_1 valid -> all ready=0 and wr_en=0; after hold drops, the grant order resumes from the held rr_ptr.
REQ-032 Reset pulsed in the same cycle as a req_0 transfer attempt -> no ready, no write next cycle, all outputs equal the REQ-025 reset values.
REQ-033 req_0 and req_1 both target rd=7 with data A and B, rr_ptr=0 -> x7 is written with A, then B on the next cycle.
